// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph table, slot length
// and the brightness/suppression configuration record.
package seg_pkg;

    localparam int SLOT_TICKS = 16;

    // All-segments-off code as seen on active-low pins.
    localparam logic [7:0] SEG_OFF_HIGH = 8'hFF;

    // Active-high gfedcba patterns, index 15 leftmost.
    localparam logic [15:0][6:0] GLYPH = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef struct packed {
        logic [3:0] bright;
        logic       lzs;
    } disp_cfg_t;

endpackage

// File: rtl/seg_glyph_rom.sv
// Nibble + decimal point to segment pattern; blank turns segments a..g off
// but leaves the dp bit under caller control.
module seg_glyph_rom
    import seg_pkg::*;
#(
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] pattern
);

    logic [7:0] pat_high;

    always_comb begin
        pat_high = {dp, (blank ? 7'h00 : GLYPH[nibble])};
        pattern  = (SEG_ACTIVE_LOW != 0) ? ~pat_high : pat_high;
    end

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed common-anode display scanner with PWM brightness,
// leading-zero suppression and frame-synchronous double-buffered updates.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  upd_valid,
    output logic                  upd_ready,
    input  logic [4*N_DIGITS-1:0] upd_hex,
    input  logic [N_DIGITS-1:0]   upd_dp,
    input  logic [3:0]            upd_bright,
    input  logic                  upd_lzs,
    output logic [N_DIGITS-1:0]   enable,
    output logic [7:0]            dispcode,
    output logic                  frame_start
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
    localparam logic [DW-1:0] DIG_MAX   = DW'(N_DIGITS - 1);
    localparam logic [3:0]    SUB_MAX   = 4'(SLOT_TICKS - 1);
    localparam logic [7:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? SEG_OFF_HIGH : ~SEG_OFF_HIGH;
    localparam disp_cfg_t     CFG_RST   = '{bright: 4'hF, lzs: 1'b0};

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sub_q, sub_d;
    logic [DW-1:0] dig_q, dig_d;

    logic [N_DIGITS-1:0][3:0] hex_q, hex_d, sh_hex_q, sh_hex_d;
    logic [N_DIGITS-1:0]      dp_q, dp_d, sh_dp_q, sh_dp_d;
    disp_cfg_t                cfg_q, cfg_d, sh_cfg_q, sh_cfg_d;
    logic                     pend_q, pend_d;

    logic [N_DIGITS-1:0] enable_q, enable_d;
    logic [7:0]          dispcode_q, dispcode_d;
    logic                frame_start_q, frame_start_d;

    logic                tick, slot_end, boundary, xfer, drive, lead;
    logic [N_DIGITS-1:0] supp, onehot;
    logic [7:0]          rom_pat;

    // Scan counters and frame boundary detection
    always_comb begin
        tick     = (presc_q == PRESC_MAX);
        slot_end = tick && (sub_q == SUB_MAX);
        boundary = slot_end && (dig_q == DIG_MAX);
        presc_d  = tick ? '0 : presc_q + 1'b1;
        sub_d    = tick ? sub_q + 4'd1 : sub_q;
        dig_d    = dig_q;
        if (slot_end) begin
            dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + 1'b1;
        end
    end

    // Shadow capture and frame-synchronous promotion to the active set.
    // A transfer can only happen with nothing pending, so it never races the copy.
    always_comb begin
        xfer     = upd_valid && !pend_q;
        sh_hex_d = sh_hex_q;
        sh_dp_d  = sh_dp_q;
        sh_cfg_d = sh_cfg_q;
        pend_d   = pend_q;
        hex_d    = hex_q;
        dp_d     = dp_q;
        cfg_d    = cfg_q;
        if (boundary && pend_q) begin
            hex_d  = sh_hex_q;
            dp_d   = sh_dp_q;
            cfg_d  = sh_cfg_q;
            pend_d = 1'b0;
        end
        if (xfer) begin
            sh_hex_d = upd_hex;
            sh_dp_d  = upd_dp;
            sh_cfg_d = '{bright: upd_bright, lzs: upd_lzs};
            pend_d   = 1'b1;
        end
    end

    // Leading-zero mask: a digit is blanked while every digit above it is zero too
    always_comb begin
        supp = '0;
        lead = cfg_q.lzs;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            lead    = lead && (hex_q[i] == 4'h0);
            supp[i] = lead;
        end
    end

    always_comb begin
        drive         = (sub_q != 4'd0) && (sub_q <= cfg_q.bright);
        onehot        = '0;
        onehot[dig_q] = 1'b1;
        enable_d      = drive ? ~onehot : '1;
        dispcode_d    = rom_pat;
        frame_start_d = boundary;
    end

    seg_glyph_rom #(
        .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_rom (
        .nibble (hex_q[dig_q]),
        .dp     (drive && dp_q[dig_q]),
        .blank  (!drive || supp[dig_q]),
        .pattern(rom_pat)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q       <= '0;
            sub_q         <= '0;
            dig_q         <= '0;
            hex_q         <= '0;
            dp_q          <= '0;
            cfg_q         <= CFG_RST;
            sh_hex_q      <= '0;
            sh_dp_q       <= '0;
            sh_cfg_q      <= CFG_RST;
            pend_q        <= 1'b0;
            enable_q      <= '1;
            dispcode_q    <= SEG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            presc_q       <= presc_d;
            sub_q         <= sub_d;
            dig_q         <= dig_d;
            hex_q         <= hex_d;
            dp_q          <= dp_d;
            cfg_q         <= cfg_d;
            sh_hex_q      <= sh_hex_d;
            sh_dp_q       <= sh_dp_d;
            sh_cfg_q      <= sh_cfg_d;
            pend_q        <= pend_d;
            enable_q      <= enable_d;
            dispcode_q    <= dispcode_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign upd_ready   = !pend_q;
    assign enable      = enable_q;
    assign dispcode    = dispcode_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver for an N-digit common-anode module; successor to the fixed 4-digit scanner. It adds per-digit decimal points, leading-zero suppression, PWM brightness with anti-ghosting dead time, and a valid/ready update port. Updates are double-buffered and take effect only at frame boundaries, so digits never tear. It sits between the CPU debug/status registers and the board display pins.

Parameters:
N_DIGITS, 4, number of digits scanned (2..8)
CLK_DIV, 50000, clock cycles per scan tick (>=2)
SEG_ACTIVE_LOW, 1, 1 = segment outputs active-low, 0 = active-high

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-low reset
upd_valid  input  1  new display data offered
upd_ready  output  1  driver can accept update
upd_hex  input  4*N_DIGITS  digit i nibble at [4i+3:4i]; digit 0 rightmost
upd_dp  input  N_DIGITS  decimal point per digit, 1 = lit
upd_bright  input  4  brightness 0..15
upd_lzs  input  1  leading-zero suppression enable
enable  output  N_DIGITS  digit anode enables, active-low, one-hot-cold
dispcode  output  8  bit0..6 = segments a..g, bit7 = dp, polarity per SEG_ACTIVE_LOW
frame_start  output  1  one-cycle pulse at start of each frame

Behaviour:
- Reset: async on reset=0. enable = all ones; dispcode = all segments off (8'hFF if SEG_ACTIVE_LOW, else 8'h00); upd_ready = 1; frame_start = 0. Prescaler, sub-slot and digit counters = 0. Active regs: hex = 0, dp = 0, bright = 15, lzs = 0. Shadow pending = 0.
- Prescaler counts 0..CLK_DIV-1 and issues a tick when it reaches CLK_DIV-1, then wraps.
- Each digit slot is 16 ticks (sub counter 0..15). The digit index advances 0..N_DIGITS-1 when sub wraps, then wraps to 0.
- Frame boundary: the cycle on which the tick occurs with sub = 15 and digit = N_DIGITS-1. frame_start pulses on the following cycle, when digit = 0 and sub = 0.
- Brightness: the digit is driven when 1 <= sub <= bright. Sub = 0 is always blank (dead time). bright = 0 gives dark; bright = 15 gives a 15/16 duty.
- When driven: enable[digit] = 0, all other bits 1; dispcode = glyph(hex[digit]) with dp[digit] in bit7. When not driven, all enables and segments are off.
- Glyphs, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. The output is inverted when SEG_ACTIVE_LOW.
- Leading-zero suppression: when lzs = 1, contiguous zero digits from N_DIGITS-1 downward are blanked (segments off, enable still toggles per PWM). Digit 0 is never suppressed. A digit's dp still lights even when the digit is suppressed.
- Outputs are registered. enable and dispcode change on the same edge, one cycle after the counter state that selects them.
- Handshake:
  - Transfer when upd_valid & upd_ready. All upd_* fields are captured into the shadow, pending is set and upd_ready drops next cycle.
  - At the frame boundary cycle, if pending = 1, shadow copies to the active regs and pending clears. upd_ready returns to 1 next cycle.
  - A transfer on the boundary cycle itself is stored in the shadow and applied at the next boundary.
  - upd_valid with upd_ready = 0 is ignored. The source must hold its data.
- Reset mid-frame: scan restarts from digit 0 and any pending update is discarded.

Decomposition:
- Shared package seg_pkg: SEG_OFF_HIGH constant, glyph table as a 16-entry constant array, SLOT_TICKS = 16.
- One natural sub-module: seg_glyph_rom, a combinational nibble+dp -> 8-bit pattern with blank input and polarity parameter.
- Counters, PWM compare, LZS mask and shadow/handshake logic stay in the top module.

Test Plan:
- CLK_DIV=2, N_DIGITS=4, release reset: enable = 4'b1111 and dispcode = 8'hFF on the first cycle. frame_start repeats every 128 clocks. Each digit shows glyph 0 (8'hC0) with enable low for 15 of 16 ticks, and enable stays 4'b1111 while sub = 0.
- Update hex = 16'h12AF, dp = 4'b0010, bright = 15: digit 0 = 8'h8E (F), digit 1 = 8'h08 (A) with dp low, digit 2 = 8'hA4, digit 3 = 8'hF9. The change appears only after the next frame_start. upd_ready is low in between.
- bright = 3: enable low for exactly 3 ticks (sub 1..3) per slot. bright = 0: enable = 4'b1111 for a whole frame.
- lzs = 1, hex = 16'h0030: digits 3 and 2 blank (8'hFF), digit 1 = 8'hB0, digit 0 = 8'hC0. hex = 16'h0000: only digit 0 shows 8'hC0.
- Two updates back-to-back: the second is stalled (ready = 0) until the boundary after the first is applied. An update accepted on the boundary cycle appears one frame later.
- Assert reset mid-slot with a pending update: outputs return to reset values immediately. After release, the pending data never appears and upd_ready = 1.
